// File: rtl/seg7_pkg.sv
// seg7_pkg: 7-segment glyph constants, reader FSM states and the glyph-to-nibble decode function.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
  function automatic logic [4:0] seg7_to_nibble(input logic [6:0] s);
    case (s)
      SEG_0:   return 5'h00;
      SEG_1:   return 5'h01;
      SEG_2:   return 5'h02;
      SEG_3:   return 5'h03;
      SEG_4:   return 5'h04;
      SEG_5:   return 5'h05;
      SEG_6:   return 5'h06;
      SEG_7:   return 5'h07;
      SEG_8:   return 5'h08;
      SEG_9:   return 5'h09;
      SEG_A:   return 5'h0A;
      SEG_B:   return 5'h0B;
      SEG_C:   return 5'h0C;
      SEG_D:   return 5'h0D;
      SEG_E:   return 5'h0E;
      SEG_F:   return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction
endpackage

// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder: combinational segment pattern to hex nibble with illegal-glyph flag.
module seg7_pattern_decoder
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);
  assign {err, nibble} = seg7_to_nibble(seg);
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: debounces a multiplexed 7-segment bus, decodes each digit and delivers
// assembled frames over a valid/ready handshake with a sticky overrun flag.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overrun
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_e                  state_q, state_d;
  logic [6:0]              snap_seg_q, snap_seg_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] slot_val_q, slot_val_d, out_value_q, out_value_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d, out_err_q, out_err_d, seen_q, seen_d;
  logic                    out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic [3:0]              nibble;
  logic                    err, one_hot, reload, cap, done;

  seg7_pattern_decoder u_dec (.seg(seg), .nibble(nibble), .err(err));

  assign one_hot   = (digit_en != '0) && ((digit_en & (digit_en - 1'b1)) == '0);
  assign out_value = out_value_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

  always_comb begin
    state_d     = state_q;
    snap_seg_d  = snap_seg_q;
    snap_en_d   = snap_en_q;
    cnt_d       = cnt_q;
    slot_val_d  = slot_val_q;
    slot_err_d  = slot_err_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    reload      = (state_q == IDLE) || (seg != snap_seg_q) || (digit_en != snap_en_q);
    if (reload) begin
      snap_seg_d = seg;
      snap_en_d  = digit_en;
      cnt_d      = one_hot ? CW'(1) : '0;
      state_d    = one_hot ? SETTLE : IDLE;
    end else if (state_q == SETTLE) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Only the SETTLE path can capture; HOLD keeps a static display from re-capturing.
    cap  = one_hot && (state_d == SETTLE) && (cnt_d == CW'(SETTLE_CYCLES));
    done = &seen_q;
    state_d = cap ? HOLD : state_d;
    seen_d  = (done ? '0 : seen_q) | (cap ? digit_en : '0);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      slot_val_d[4*k +: 4] = (cap && digit_en[k]) ? nibble : slot_val_q[4*k +: 4];
      slot_err_d[k]        = (cap && digit_en[k]) ? err : slot_err_q[k];
    end
    if (done) begin
      out_value_d = slot_val_q;
      out_err_d   = slot_err_q;
      out_valid_d = 1'b1;
      overrun_d   = overrun_q | (out_valid_q & ~out_ready);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_seg_q  <= '0;
      snap_en_q   <= '0;
      cnt_q       <= '0;
      slot_val_q  <= '0;
      slot_err_q  <= '0;
      seen_q      <= '0;
      out_value_q <= '0;
      out_err_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_seg_q  <= snap_seg_d;
      snap_en_q   <= snap_en_d;
      cnt_q       <= cnt_d;
      slot_val_q  <= slot_val_d;
      slot_err_q  <= slot_err_d;
      seen_q      <= seen_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scans checked every cycle against a run-length frame model.
module tb_seg7_scan_reader;
  localparam int N = 4;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [6:0]     seg = '0;
  logic [N-1:0]   digit_en = '0;
  logic [4*N-1:0] out_value;
  logic [N-1:0]   out_err;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           overrun;

  always #5 clk = ~clk;

  seg7_scan_reader #(.NUM_DIGITS(N), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .seg(seg), .digit_en(digit_en), .out_value(out_value),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] glyph [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r = 5'h10;
    for (int i = 0; i < 16; i++) if (glyph[i] == s) r = {1'b0, 4'(i)};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a digit is captured when the same one-hot strobe and pattern have been seen on
  // exactly S consecutive edges; a full seen-mask publishes the frame on the following edge.
  logic [3:0]     m_nib [N];
  logic [N-1:0]   m_bad = '0, m_seen = '0, m_err = '0;
  logic [4*N-1:0] m_value = '0;
  logic           m_valid = 1'b0, m_ovr = 1'b0;
  int             run = 0;
  logic [6:0]     pseg = '0;
  logic [N-1:0]   pen = '0;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) m_nib[k] = 4'h0;
      m_bad = '0; m_seen = '0; m_err = '0; m_value = '0;
      m_valid = 1'b0; m_ovr = 1'b0; run = 0; pseg = '0; pen = '0;
    end else begin
      logic oh;
      logic [4:0] d;
      oh = $countones(digit_en) == 1;
      run = (oh && seg == pseg && digit_en == pen) ? run + 1 : (oh ? 1 : 0);
      pseg = seg;
      pen = digit_en;
      if (m_seen == '1) begin
        if (m_valid && !out_ready) m_ovr = 1'b1;
        for (int k = 0; k < N; k++) m_value[4*k +: 4] = m_nib[k];
        m_err = m_bad;
        m_valid = 1'b1;
        m_seen = '0;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
      if (run == S) begin
        d = decode(seg);
        for (int k = 0; k < N; k++) if (digit_en[k]) begin
          m_nib[k] = d[3:0];
          m_bad[k] = d[4];
          m_seen[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_value", 32'(out_value), 32'(m_value));
    check("cyc_err", 32'(out_err), 32'(m_err));
    check("cyc_valid", 32'(out_valid), 32'(m_valid));
    check("cyc_overrun", 32'(overrun), 32'(m_ovr));
  end

  task automatic step(input logic [6:0] s, input logic [N-1:0] e);
    @(negedge clk);
    seg = s;
    digit_en = e;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    logic [N-1:0] e = 1;
    e = e << d;
    repeat (n) step(s, e);
  endtask

  task automatic blank(input int n);
    repeat (n) step(7'b0, '0);
  endtask

  task automatic accept();
    @(negedge clk);
    seg = '0;
    digit_en = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("accept_drop", 32'(out_valid), 0);
  endtask

  task automatic lit(input string tag, input logic [15:0] v, input logic [3:0] e,
                     input logic va, input logic ov);
    check({tag, "_value"}, 32'(out_value), 32'(v));
    check({tag, "_err"}, 32'(out_err), 32'(e));
    check({tag, "_valid"}, 32'(out_valid), 32'(va));
    check({tag, "_overrun"}, 32'(overrun), 32'(ov));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lit("reset", 16'h0, 4'h0, 1'b0, 1'b0);
    for (int d = 0; d < 4; d++) show(d, glyph[d+1], 5);
    blank(2);
    lit("t1", 16'h4321, 4'h0, 1'b1, 1'b0);
    accept();
    step(glyph[0], 4'b0001);
    show(0, glyph[1], 3);
    for (int d = 1; d < 4; d++) show(d, glyph[0], 5);
    blank(2);
    lit("t2_glitch", 16'h0001, 4'h0, 1'b1, 1'b0);
    accept();
    show(0, glyph[0], 5);
    show(1, glyph[0], 5);
    show(2, 7'b1010101, 5);
    show(3, glyph[0], 5);
    blank(2);
    lit("t3_illegal", 16'h0000, 4'b0100, 1'b1, 1'b0);
    accept();
    for (int d = 0; d < 4; d++) show(d, glyph[4-d], 5);
    blank(2);
    for (int d = 0; d < 4; d++) show(d, glyph[13-d], 5);
    blank(2);
    lit("t4_overrun", 16'hABCD, 4'h0, 1'b1, 1'b1);
    accept();
    lit("t4_after", 16'hABCD, 4'h0, 1'b0, 1'b1);
    show(1, glyph[5], 50);
    blank(2);
    step(glyph[9], 4'b0011);
    step(glyph[9], 4'b0011);
    step(glyph[9], 4'b0011);
    step(glyph[9], 4'b0011);
    blank(2);
    lit("t5_partial", 16'hABCD, 4'h0, 1'b0, 1'b1);
    show(0, glyph[6], 5);
    show(2, glyph[7], 5);
    show(3, glyph[8], 5);
    blank(2);
    lit("t5_static", 16'h8756, 4'h0, 1'b1, 1'b1);
    accept();
    show(0, glyph[9], 5);
    show(1, glyph[10], 5);
    @(negedge clk);
    rst = 1'b1;
    seg = '0;
    digit_en = '0;
    @(negedge clk);
    rst = 1'b0;
    lit("t6_rst", 16'h0, 4'h0, 1'b0, 1'b0);
    show(0, glyph[15], 5);
    show(1, glyph[15], 5);
    show(2, glyph[0], 5);
    show(3, glyph[0], 5);
    blank(2);
    lit("t6_new", 16'h00FF, 4'h0, 1'b1, 1'b0);
    for (int d = 0; d < 3; d++) show(d, glyph[8-d], 5);
    show(3, glyph[5], 3);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    seg = '0;
    digit_en = '0;
    lit("t6_same_edge", 16'h5678, 4'h0, 1'b1, 1'b0);
    accept();
    blank(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
